// File: rtl/gpio_bank_pkg.sv
// Shared register map and bus payload for the GPIO bank.
package gpio_bank_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned ARM_W  = 3;

   localparam logic [ADDR_W-1:0] GPIO_DATA_OUT   = 4'd0;
   localparam logic [ADDR_W-1:0] GPIO_DIR        = 4'd1;
   localparam logic [ADDR_W-1:0] GPIO_DATA_IN    = 4'd2;
   localparam logic [ADDR_W-1:0] GPIO_SET        = 4'd3;
   localparam logic [ADDR_W-1:0] GPIO_CLR        = 4'd4;
   localparam logic [ADDR_W-1:0] GPIO_TGL        = 4'd5;
   localparam logic [ADDR_W-1:0] GPIO_IRQ_EN     = 4'd6;
   localparam logic [ADDR_W-1:0] GPIO_IRQ_RISE   = 4'd7;
   localparam logic [ADDR_W-1:0] GPIO_IRQ_FALL   = 4'd8;
   localparam logic [ADDR_W-1:0] GPIO_IRQ_STATUS = 4'd9;

   typedef struct packed {
      logic              sel;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } gpio_bus_req_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser for asynchronous pad inputs.
module gpio_sync #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] chain_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction, atomic set/clr/toggle, synchronised inputs, edge interrupts.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int unsigned N_PINS      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] OUT_RESET   = '0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              sel,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   input  logic [N_PINS-1:0] gpio_in,
   output logic [N_PINS-1:0] gpio_out,
   output logic [N_PINS-1:0] gpio_oe,
   output logic              irq
);

   localparam int unsigned ARM_MAX = SYNC_STAGES + 1;

   gpio_bus_req_t     req;
   logic              wr_en;
   logic [N_PINS-1:0] wbits;
   logic [N_PINS-1:0] sync_q;
   logic [N_PINS-1:0] edges;
   logic              armed;

   logic [N_PINS-1:0] data_out_q, data_out_d;
   logic [N_PINS-1:0] dir_q, dir_d;
   logic [N_PINS-1:0] irq_en_q, irq_en_d;
   logic [N_PINS-1:0] irq_rise_q, irq_rise_d;
   logic [N_PINS-1:0] irq_fall_q, irq_fall_d;
   logic [N_PINS-1:0] irq_status_q, irq_status_d;
   logic [N_PINS-1:0] prev_q;
   logic [ARM_W-1:0]  arm_q, arm_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] rd_val;

   assign req   = '{sel: sel, we: we, addr: addr, wdata: wdata};
   assign wr_en = req.sel & req.we;
   assign wbits = req.wdata[N_PINS-1:0];

   gpio_sync #(
      .WIDTH  (N_PINS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (gpio_in),
      .q_o    (sync_q)
   );

   // Edges are ignored until the synchroniser and prev flop hold real pad data.
   assign armed = (arm_q == ARM_W'(ARM_MAX));
   assign edges = armed ? ((sync_q & ~prev_q & irq_rise_q) | (~sync_q & prev_q & irq_fall_q))
                        : '0;

   always_comb begin
      data_out_d   = data_out_q;
      dir_d        = dir_q;
      irq_en_d     = irq_en_q;
      irq_rise_d   = irq_rise_q;
      irq_fall_d   = irq_fall_q;
      irq_status_d = irq_status_q | edges;
      arm_d        = armed ? arm_q : arm_q + ARM_W'(1);
      irq_d        = |(irq_status_q & irq_en_q);
      if (wr_en) begin
         case (req.addr)
            GPIO_DATA_OUT:   data_out_d   = wbits;
            GPIO_DIR:        dir_d        = wbits;
            GPIO_SET:        data_out_d   = data_out_q | wbits;
            GPIO_CLR:        data_out_d   = data_out_q & ~wbits;
            GPIO_TGL:        data_out_d   = data_out_q ^ wbits;
            GPIO_IRQ_EN:     irq_en_d     = wbits;
            GPIO_IRQ_RISE:   irq_rise_d   = wbits;
            GPIO_IRQ_FALL:   irq_fall_d   = wbits;
            // A fresh edge in the clearing cycle must not be lost.
            GPIO_IRQ_STATUS: irq_status_d = (irq_status_q & ~wbits) | edges;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_out_q   <= OUT_RESET[N_PINS-1:0];
         dir_q        <= '0;
         irq_en_q     <= '0;
         irq_rise_q   <= '0;
         irq_fall_q   <= '0;
         irq_status_q <= '0;
         prev_q       <= '0;
         arm_q        <= '0;
         irq_q        <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         dir_q        <= dir_d;
         irq_en_q     <= irq_en_d;
         irq_rise_q   <= irq_rise_d;
         irq_fall_q   <= irq_fall_d;
         irq_status_q <= irq_status_d;
         prev_q       <= sync_q;
         arm_q        <= arm_d;
         irq_q        <= irq_d;
      end
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         GPIO_DATA_OUT:   rd_val = DATA_W'(data_out_q);
         GPIO_DIR:        rd_val = DATA_W'(dir_q);
         GPIO_DATA_IN:    rd_val = DATA_W'(sync_q);
         GPIO_IRQ_EN:     rd_val = DATA_W'(irq_en_q);
         GPIO_IRQ_RISE:   rd_val = DATA_W'(irq_rise_q);
         GPIO_IRQ_FALL:   rd_val = DATA_W'(irq_fall_q);
         GPIO_IRQ_STATUS: rd_val = DATA_W'(irq_status_q);
         default: ;
      endcase
   end

   assign rdata    = sel ? rd_val : '0;
   assign gpio_out = data_out_q;
   assign gpio_oe  = dir_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: register access, sync latency, edge interrupts, reset.
module tb_gpio_bank;
   import gpio_bank_pkg::*;

   localparam int unsigned N    = 8;
   localparam int unsigned SYNC = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [N-1:0] gpio_in = '0;
   logic [N-1:0] gpio_out;
   logic [N-1:0] gpio_oe;
   logic        irq;
   logic        irq_s;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   gpio_bank #(
      .N_PINS      (N),
      .SYNC_STAGES (SYNC),
      .OUT_RESET   (32'hA5)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .sel      (sel),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      sel = 1'b0; we = 1'b0;
   endtask

   // Expected value is queued at issue and retired when rdata is sampled.
   task automatic rd(input logic [3:0] a, input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      irq_s = irq;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, rdata, e.exp);
      end
      @(posedge clk);
      #1;
      sel = 1'b0;
   endtask

   initial begin
      // Reset values
      #12;
      check("rst_out", 32'(gpio_out), 32'hA5);
      check("rst_oe", 32'(gpio_oe), 32'h00);
      check("rst_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rd(4'(i), $sformatf("rst_reg%0d", i), (i == 0) ? 32'hA5 : 32'h0);
      end
      sel = 1'b0; addr = 4'd0;
      #1;
      check("nosel_rdata", rdata, 32'h0);
      tick(1);

      // Atomic output updates
      wr(GPIO_DATA_OUT, 32'h0F); check("out_wr", 32'(gpio_out), 32'h0F);
      wr(GPIO_SET, 32'h30);      check("out_set", 32'(gpio_out), 32'h3F);
      wr(GPIO_CLR, 32'h01);      check("out_clr", 32'(gpio_out), 32'h3E);
      wr(GPIO_TGL, 32'h81);      check("out_tgl", 32'(gpio_out), 32'hBF);
      rd(GPIO_DATA_OUT, "out_rd", 32'hBF);
      wr(GPIO_SET, 32'hFFFF_FF40);
      rd(GPIO_DATA_OUT, "out_set_wide", 32'hFF);
      wr(GPIO_DIR, 32'hFFFF_FF3C);
      check("oe_wr", 32'(gpio_oe), 32'h3C);
      rd(GPIO_DIR, "dir_rd", 32'h3C);
      wr(GPIO_DIR, 32'h0);
      check("oe_clr", 32'(gpio_oe), 32'h00);

      // Input synchroniser latency
      gpio_in = 8'h04;
      for (int k = 0; k <= int'(SYNC); k++) begin
         rd(GPIO_DATA_IN, $sformatf("din_lat%0d", k), (k == int'(SYNC)) ? 32'h04 : 32'h0);
      end
      wr(GPIO_DATA_IN, 32'hFF);
      rd(GPIO_DATA_IN, "din_ro", 32'h04);
      rd(GPIO_IRQ_STATUS, "stat_noen", 32'h0);

      // Rising edge interrupt and W1C
      wr(GPIO_IRQ_RISE, 32'h04);
      wr(GPIO_IRQ_EN, 32'h04);
      gpio_in = 8'h00;
      tick(4);
      gpio_in = 8'h04;
      for (int k = 0; k <= int'(SYNC) + 2; k++) begin
         rd(GPIO_IRQ_STATUS, $sformatf("rise_stat%0d", k), (k >= int'(SYNC) + 1) ? 32'h04 : 32'h0);
         check($sformatf("rise_irq%0d", k), 32'(irq_s), (k >= int'(SYNC) + 2) ? 32'd1 : 32'd0);
      end
      wr(GPIO_IRQ_STATUS, 32'h04);
      rd(GPIO_IRQ_STATUS, "w1c_stat", 32'h0);
      check("w1c_irq_hold", 32'(irq_s), 32'd1);
      rd(GPIO_IRQ_STATUS, "w1c_stat2", 32'h0);
      check("w1c_irq_low", 32'(irq_s), 32'd0);

      // Edge coinciding with W1C keeps the bit set
      gpio_in = 8'h00; tick(5);
      gpio_in = 8'h04; tick(5);
      rd(GPIO_IRQ_STATUS, "pre_stat", 32'h04);
      check("pre_irq", 32'(irq_s), 32'd1);
      gpio_in = 8'h00; tick(5);
      rd(GPIO_IRQ_STATUS, "nofall_stat", 32'h04);
      gpio_in = 8'h04;
      tick(2);
      wr(GPIO_IRQ_STATUS, 32'h04);
      rd(GPIO_IRQ_STATUS, "setwin_stat", 32'h04);
      check("setwin_irq", 32'(irq_s), 32'd1);
      rd(GPIO_IRQ_STATUS, "setwin_stat2", 32'h04);
      check("setwin_irq2", 32'(irq_s), 32'd1);

      // Status sets while masked, irq stays low
      wr(GPIO_IRQ_EN, 32'h0);
      wr(GPIO_IRQ_STATUS, 32'h04);
      tick(2);
      rd(GPIO_IRQ_STATUS, "mask_clr", 32'h0);
      check("mask_irq0", 32'(irq_s), 32'd0);
      wr(GPIO_IRQ_FALL, 32'h04);
      gpio_in = 8'h00;
      tick(5);
      rd(GPIO_IRQ_STATUS, "mask_fall_stat", 32'h04);
      check("mask_irq1", 32'(irq_s), 32'd0);
      rd(GPIO_IRQ_FALL, "fall_rd", 32'h04);
      rd(GPIO_IRQ_RISE, "rise_rd", 32'h04);
      rd(GPIO_IRQ_EN, "en_rd", 32'h0);

      // Pins high through reset release raise no edges
      gpio_in = 8'hFF;
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      tick(6);
      rd(GPIO_IRQ_STATUS, "rel_stat", 32'h0);
      rd(GPIO_DATA_IN, "rel_din", 32'hFF);
      rd(GPIO_DATA_OUT, "rel_out", 32'hA5);

      // Asynchronous reset drops a pending irq
      wr(GPIO_IRQ_RISE, 32'h01);
      wr(GPIO_IRQ_EN, 32'h01);
      gpio_in = 8'hFE; tick(5);
      gpio_in = 8'hFF; tick(5);
      rd(GPIO_IRQ_STATUS, "mid_stat", 32'h01);
      check("mid_irq", 32'(irq_s), 32'd1);
      resetn = 1'b0;
      #2;
      check("async_irq", 32'(irq), 32'd0);
      check("async_out", 32'(gpio_out), 32'hA5);
      check("async_oe", 32'(gpio_oe), 32'h00);
      #10;
      resetn = 1'b1;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
